// File: rtl/hazard_ctrl_v2.sv
// Hazard controller beside DE: load-use, long-unit scoreboard and CSR/fence
// serialization stalls, plus a saturating count of DE stall cycles.
module hazard_ctrl_v2 #(
  parameter int REAR_STAGES = 4,
  parameter int LOAD_WIN    = 2,
  parameter int NUM_SRC     = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     de_valid,
  input  logic [5*NUM_SRC-1:0]     de_rs,
  input  logic [NUM_SRC-1:0]       de_rs_used,
  input  logic [4:0]               de_rd,
  input  logic                     de_is_serial,
  input  logic                     de_is_long,
  input  logic [REAR_STAGES-1:0]   st_valid,
  input  logic [5*REAR_STAGES-1:0] st_rd,
  input  logic [REAR_STAGES-1:0]   st_is_load,
  input  logic                     lu_done,
  input  logic [4:0]               lu_rd,
  input  logic                     redirect,
  output logic                     stall_pc,
  output logic                     stall_f2,
  output logic                     stall_de,
  output logic                     flush_ex,
  output logic                     serial_busy,
  output logic [31:0]              sb_pending,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GO    = 2'd2
  } ser_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ser_state_t  state;
  logic [31:0] sb_q;
  logic [31:0] sb_next;
  logic        load_use;
  logic        sb_raw;
  logic        sb_struct;
  logic        rear_busy;
  logic        ser_stall;
  logic        hz;
  logic        issue;
  logic        unused_bits;

  // Stages at or beyond LOAD_WIN forward their load data, so only part of st_rd/st_is_load matters.
  assign unused_bits = ^{st_rd, st_is_load};

  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (de_rs_used[k] && (de_rs[5*k +: 5] != 5'd0)) begin
        if (sb_q[de_rs[5*k +: 5]]) sb_raw = 1'b1;
        for (int i = 0; i < LOAD_WIN; i++) begin
          if (st_valid[i] && st_is_load[i] && (st_rd[5*i +: 5] == de_rs[5*k +: 5]))
            load_use = 1'b1;
        end
      end
    end
  end

  assign sb_struct = de_is_long & (|sb_q);
  assign rear_busy = (|st_valid) | (|sb_q);
  assign ser_stall = (state == DRAIN) |
                     ((state == IDLE) & de_valid & de_is_serial & rear_busy);

  assign hz       = de_valid & ~redirect & (load_use | sb_raw | sb_struct | ser_stall);
  assign issue    = de_valid & ~hz;
  assign stall_pc = hz;
  assign stall_f2 = hz;
  assign stall_de = hz;
  assign flush_ex = hz;

  assign serial_busy = (state != IDLE);
  assign sb_pending  = sb_q;

  // Redirect squashes whatever serial op was waiting, so it overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (redirect) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (de_valid && de_is_serial && rear_busy) state <= DRAIN;
        DRAIN:   if (!rear_busy) state <= GO;
        GO:      if (issue) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Set is applied after clear so a same-register collision keeps the bit.
  always_comb begin
    sb_next = sb_q;
    if (lu_done) sb_next[lu_rd] = 1'b0;
    if (issue && de_is_long && (de_rd != 5'd0)) sb_next[de_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_cnt <= '0;
    else if (hz && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed bench for hazard_ctrl_v2: a behavioural model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_hazard_ctrl_v2;

  localparam int LW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_valid;
  logic [9:0]  de_rs;
  logic [1:0]  de_rs_used;
  logic [4:0]  de_rd;
  logic        de_is_serial;
  logic        de_is_long;
  logic [3:0]  st_valid;
  logic [19:0] st_rd;
  logic [3:0]  st_is_load;
  logic        lu_done;
  logic [4:0]  lu_rd;
  logic        redirect;

  logic        stall_pc, stall_f2, stall_de, flush_ex, serial_busy;
  logic [31:0] sb_pending;
  logic [15:0] stall_cnt;
  logic        s_stall_pc, s_stall_f2, s_stall_de, s_flush_ex, s_serial_busy;
  logic [31:0] s_sb_pending;
  logic [3:0]  s_stall_cnt;

  typedef struct {
    logic        de_valid;
    logic [9:0]  de_rs;
    logic [1:0]  de_rs_used;
    logic [4:0]  de_rd;
    logic        de_is_serial;
    logic        de_is_long;
    logic [3:0]  st_valid;
    logic [19:0] st_rd;
    logic [3:0]  st_is_load;
    logic        lu_done;
    logic [4:0]  lu_rd;
    logic        redirect;
  } stim_t;

  stim_t nxt;
  int    tests_run = 0;
  int    tests_failed = 0;

  // Behavioural model state: pending long-op registers, serial-op phase, total stalls.
  bit    m_sb [32];
  bit    m_wait = 1'b0;
  bit    m_go = 1'b0;
  int    m_cnt = 0;

  hazard_ctrl_v2 dut (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
    .de_rd(de_rd), .de_is_serial(de_is_serial), .de_is_long(de_is_long), .st_valid(st_valid),
    .st_rd(st_rd), .st_is_load(st_is_load), .lu_done(lu_done), .lu_rd(lu_rd),
    .redirect(redirect), .stall_pc(stall_pc), .stall_f2(stall_f2), .stall_de(stall_de),
    .flush_ex(flush_ex), .serial_busy(serial_busy), .sb_pending(sb_pending),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl_v2 #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
    .de_rd(de_rd), .de_is_serial(de_is_serial), .de_is_long(de_is_long), .st_valid(st_valid),
    .st_rd(st_rd), .st_is_load(st_is_load), .lu_done(lu_done), .lu_rd(lu_rd),
    .redirect(redirect), .stall_pc(s_stall_pc), .stall_f2(s_stall_f2), .stall_de(s_stall_de),
    .flush_ex(s_flush_ex), .serial_busy(s_serial_busy), .sb_pending(s_sb_pending),
    .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_sb_any();
    for (int i = 1; i < 32; i++) if (m_sb[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return (st_valid != 4'd0) || m_sb_any();
  endfunction

  function automatic bit m_hz();
    bit         lu;
    bit         raw;
    logic [4:0] r;
    lu  = 1'b0;
    raw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r = de_rs[5*k +: 5];
      if (de_rs_used[k] && r != 5'd0) begin
        if (m_sb[r]) raw = 1'b1;
        for (int i = 0; i < LW; i++)
          if (st_valid[i] && st_is_load[i] && st_rd[5*i +: 5] == r) lu = 1'b1;
      end
    end
    return de_valid && !redirect &&
           (lu || raw || (de_is_long && m_sb_any()) || m_wait ||
            (!m_go && de_is_serial && m_busy()));
  endfunction

  function automatic logic [31:0] m_sb_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_sb[i];
    return v;
  endfunction

  function automatic logic [31:0] sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_sb[i] <= 1'b0;
      m_wait <= 1'b0;
      m_go   <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (m_hz()) m_cnt <= m_cnt + 1;
      if (lu_done) m_sb[lu_rd] <= 1'b0;
      if (de_valid && !m_hz() && de_is_long && de_rd != 5'd0) m_sb[de_rd] <= 1'b1;
      if (redirect) begin
        m_wait <= 1'b0;
        m_go   <= 1'b0;
      end else if (m_wait) begin
        if (!m_busy()) begin
          m_wait <= 1'b0;
          m_go   <= 1'b1;
        end
      end else if (m_go) begin
        if (de_valid && !m_hz()) m_go <= 1'b0;
      end else if (de_valid && de_is_serial && m_busy()) begin
        m_wait <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_stall_pc", 32'(stall_pc), 32'(m_hz()));
    checkOutput("model_stall_f2", 32'(stall_f2), 32'(m_hz()));
    checkOutput("model_stall_de", 32'(stall_de), 32'(m_hz()));
    checkOutput("model_flush_ex", 32'(flush_ex), 32'(m_hz()));
    checkOutput("model_serial_busy", 32'(serial_busy), 32'(m_wait || m_go));
    checkOutput("model_sb_pending", sb_pending, m_sb_vec());
    checkOutput("model_stall_cnt", 32'(stall_cnt), sat(m_cnt, 65535));
    checkOutput("model_small_stall_de", 32'(s_stall_de), 32'(m_hz()));
    checkOutput("model_small_sb", s_sb_pending, m_sb_vec());
    checkOutput("model_small_cnt", 32'(s_stall_cnt), sat(m_cnt, 15));
  end

  task automatic clearStim();
    nxt.de_valid     = 1'b0;
    nxt.de_rs        = '0;
    nxt.de_rs_used   = '0;
    nxt.de_rd        = '0;
    nxt.de_is_serial = 1'b0;
    nxt.de_is_long   = 1'b0;
    nxt.st_valid     = '0;
    nxt.st_rd        = '0;
    nxt.st_is_load   = '0;
    nxt.lu_done      = 1'b0;
    nxt.lu_rd        = '0;
    nxt.redirect     = 1'b0;
  endtask

  task automatic setStage(input int i, input logic [4:0] rd, input logic load);
    nxt.st_valid[i]      = 1'b1;
    nxt.st_rd[5*i +: 5]  = rd;
    nxt.st_is_load[i]    = load;
  endtask

  task automatic driveNxt();
    de_valid     = nxt.de_valid;
    de_rs        = nxt.de_rs;
    de_rs_used   = nxt.de_rs_used;
    de_rd        = nxt.de_rd;
    de_is_serial = nxt.de_is_serial;
    de_is_long   = nxt.de_is_long;
    st_valid     = nxt.st_valid;
    st_rd        = nxt.st_rd;
    st_is_load   = nxt.st_is_load;
    lu_done      = nxt.lu_done;
    lu_rd        = nxt.lu_rd;
    redirect     = nxt.redirect;
  endtask

  // Inputs change just after a rising edge; checks happen just after the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    driveNxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clearStim();
    driveNxt();
    #8;
    checkOutput("reset_stall_de", 32'(stall_de), 32'd0);
    checkOutput("reset_serial_busy", 32'(serial_busy), 32'd0);
    checkOutput("reset_sb", sb_pending, 32'd0);
    checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
    #4;
    rst_n = 1'b1;
    applyStimulus();

    // Load-use across the two non-forwardable stages
    clearStim(); setStage(0, 5'd5, 1'b1);
    nxt.de_valid = 1'b1; nxt.de_rs[4:0] = 5'd5; nxt.de_rs_used = 2'b01;
    applyStimulus();
    checkOutput("lu_ex_stall", 32'(stall_de), 32'd1);
    checkOutput("lu_ex_flush", 32'(flush_ex), 32'd1);
    nxt.st_valid = '0; nxt.st_is_load = '0; setStage(1, 5'd5, 1'b1);
    applyStimulus();
    checkOutput("lu_m1_stall", 32'(stall_de), 32'd1);
    nxt.st_valid = '0; nxt.st_is_load = '0; setStage(2, 5'd5, 1'b1);
    applyStimulus();
    checkOutput("lu_m2_release", 32'(stall_de), 32'd0);
    checkOutput("lu_cnt", 32'(stall_cnt), 32'd2);

    // x0 and unused sources never stall
    clearStim(); setStage(0, 5'd0, 1'b1);
    nxt.de_valid = 1'b1; nxt.de_rs_used = 2'b01;
    applyStimulus();
    checkOutput("lu_x0", 32'(stall_de), 32'd0);
    clearStim(); setStage(0, 5'd9, 1'b1);
    nxt.de_valid = 1'b1; nxt.de_rs = {5'd9, 5'd3}; nxt.de_rs_used = 2'b01;
    applyStimulus();
    checkOutput("lu_unused_src", 32'(stall_de), 32'd0);

    // Scoreboard RAW, structural hazard and set-beats-clear
    clearStim(); nxt.de_valid = 1'b1; nxt.de_is_long = 1'b1; nxt.de_rd = 5'd7;
    applyStimulus();
    checkOutput("long_issue", 32'(stall_de), 32'd0);
    clearStim();
    applyStimulus();
    checkOutput("sb_set7", sb_pending, 32'h80);
    nxt.de_valid = 1'b1; nxt.de_rs[4:0] = 5'd7; nxt.de_rs_used = 2'b01;
    applyStimulus();
    checkOutput("raw_stall1", 32'(stall_de), 32'd1);
    applyStimulus();
    checkOutput("raw_stall2", 32'(stall_de), 32'd1);
    nxt.lu_done = 1'b1; nxt.lu_rd = 5'd7;
    applyStimulus();
    checkOutput("raw_stall_done", 32'(stall_de), 32'd1);
    nxt.lu_done = 1'b0;
    applyStimulus();
    checkOutput("raw_release", 32'(stall_de), 32'd0);
    checkOutput("sb_cleared", sb_pending, 32'd0);
    clearStim(); nxt.de_valid = 1'b1; nxt.de_is_long = 1'b1; nxt.de_rd = 5'd7;
    applyStimulus();
    nxt.de_rd = 5'd8;
    applyStimulus();
    checkOutput("struct_stall", 32'(stall_de), 32'd1);
    nxt.lu_done = 1'b1; nxt.lu_rd = 5'd7;
    applyStimulus();
    checkOutput("struct_stall_done", 32'(stall_de), 32'd1);
    nxt.de_rd = 5'd7;
    applyStimulus();
    checkOutput("set_clear_issue", 32'(stall_de), 32'd0);
    clearStim();
    applyStimulus();
    checkOutput("set_wins", sb_pending, 32'h80);
    nxt.lu_done = 1'b1; nxt.lu_rd = 5'd7;
    applyStimulus();
    clearStim();
    applyStimulus();
    checkOutput("sb_empty", sb_pending, 32'd0);
    checkOutput("cnt_after_sb", 32'(stall_cnt), 32'd7);

    // Serial op draining a full rear pipeline
    clearStim();
    for (int i = 0; i < 4; i++) setStage(i, 5'(i + 1), 1'b0);
    nxt.de_valid = 1'b1; nxt.de_is_serial = 1'b1;
    applyStimulus();
    checkOutput("csr_stall_idle", 32'(stall_de), 32'd1);
    checkOutput("csr_busy_idle", 32'(serial_busy), 32'd0);
    nxt.st_valid = 4'b1110;
    applyStimulus();
    checkOutput("csr_busy_drain", 32'(serial_busy), 32'd1);
    checkOutput("csr_stall_drain", 32'(stall_de), 32'd1);
    nxt.st_valid = 4'b1100;
    applyStimulus();
    nxt.st_valid = 4'b1000;
    applyStimulus();
    nxt.st_valid = 4'b0000;
    applyStimulus();
    checkOutput("csr_stall_last", 32'(stall_de), 32'd1);
    applyStimulus();
    checkOutput("csr_go_stall", 32'(stall_de), 32'd0);
    checkOutput("csr_go_busy", 32'(serial_busy), 32'd1);
    clearStim();
    applyStimulus();
    checkOutput("csr_back_idle", 32'(serial_busy), 32'd0);
    checkOutput("csr_cnt", 32'(stall_cnt), 32'd12);
    nxt.de_valid = 1'b1; nxt.de_is_serial = 1'b1;
    applyStimulus();
    checkOutput("csr_empty_stall", 32'(stall_de), 32'd0);
    clearStim();
    applyStimulus();
    checkOutput("csr_empty_busy", 32'(serial_busy), 32'd0);

    // Redirect during DRAIN (rear kept busy by the scoreboard)
    clearStim(); nxt.de_valid = 1'b1; nxt.de_is_long = 1'b1; nxt.de_rd = 5'd3;
    applyStimulus();
    clearStim(); nxt.de_valid = 1'b1; nxt.de_is_serial = 1'b1;
    applyStimulus();
    checkOutput("rd_stall_idle", 32'(stall_de), 32'd1);
    applyStimulus();
    checkOutput("rd_drain_busy", 32'(serial_busy), 32'd1);
    nxt.redirect = 1'b1;
    applyStimulus();
    checkOutput("rd_stall_drop", 32'(stall_de), 32'd0);
    checkOutput("rd_flush_drop", 32'(flush_ex), 32'd0);
    clearStim();
    applyStimulus();
    checkOutput("rd_idle", 32'(serial_busy), 32'd0);
    checkOutput("rd_sb_kept", sb_pending, 32'h8);
    checkOutput("rd_cnt", 32'(stall_cnt), 32'd14);

    // Asynchronous reset in the middle of DRAIN
    nxt.de_valid = 1'b1; nxt.de_is_serial = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_pre_busy", 32'(serial_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_stall", 32'(stall_de), 32'd0);
    checkOutput("rst_async_busy", 32'(serial_busy), 32'd0);
    checkOutput("rst_async_sb", sb_pending, 32'd0);
    checkOutput("rst_async_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clearStim();
    applyStimulus();
    checkOutput("rst_post_busy", 32'(serial_busy), 32'd0);
    checkOutput("rst_post_cnt", 32'(stall_cnt), 32'd0);

    // Saturation of the 4-bit counter after 20 stall cycles
    clearStim(); setStage(0, 5'd5, 1'b1);
    nxt.de_valid = 1'b1; nxt.de_rs[4:0] = 5'd5; nxt.de_rs_used = 2'b01;
    repeat (20) applyStimulus();
    clearStim();
    applyStimulus();
    checkOutput("sat_small", 32'(s_stall_cnt), 32'd15);
    checkOutput("sat_wide", 32'(stall_cnt), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
